// File: rtl/lcd_init_pkg.sv
// lcd_init_pkg: sequencer states, HD44780 command bytes and a wait-clamp helper shared by lcd_init_seq
package lcd_init_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PWRUP = 3'd1;
  localparam logic [2:0] ST_WAKE  = 3'd2;
  localparam logic [2:0] ST_SET4  = 3'd3;
  localparam logic [2:0] ST_CMD   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [7:0] CMD_WAKE    = 8'h30;
  localparam logic [7:0] CMD_DOFF    = 8'h08;
  localparam logic [7:0] CMD_CLR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_DON     = 8'h0C;
  localparam logic [7:0] CMD_DON_CUR = 8'h0F;
  localparam logic [3:0] NIB_SET4    = 4'h2;
  function automatic logic [31:0] clamp1(input int v);
    return (v < 1) ? 32'd1 : 32'(v);
  endfunction
endpackage

// File: rtl/lcd_init_seq_strobe.sv
// lcd_strobe: one LCD write -- setup cycle, E pulse, optional low-nibble gap and pulse, then settle wait
module lcd_strobe #(
  parameter int EN_CYC = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        pair,
  input  logic [7:0]  data,
  input  logic [31:0] wlen,
  output logic [7:0]  dato,
  output logic        e,
  output logic        done
);
  import lcd_init_pkg::*;
  localparam logic [31:0] EN = clamp1(EN_CYC);
  localparam logic [2:0] P_IDLE  = 3'd0;
  localparam logic [2:0] P_SETUP = 3'd1;
  localparam logic [2:0] P_HIGH  = 3'd2;
  localparam logic [2:0] P_GAP   = 3'd3;
  localparam logic [2:0] P_WAIT  = 3'd4;
  logic [2:0]  ph;
  logic [31:0] cnt;
  logic        low;
  // phase walk of a single write; go restarts at setup so writes can run back to back
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ph  <= P_IDLE;
      cnt <= '0;
      low <= 1'b0;
    end else if (go) begin
      ph  <= P_SETUP;
      cnt <= '0;
      low <= 1'b0;
    end else
      case (ph)
        P_SETUP: ph <= P_HIGH;
        P_HIGH:
          if (cnt == EN - 32'd1) begin
            cnt <= '0;
            ph  <= (pair && !low) ? P_GAP : P_WAIT;
            low <= pair;
          end else cnt <= cnt + 32'd1;
        P_GAP:
          if (cnt == EN - 32'd1) begin
            cnt <= '0;
            ph  <= P_HIGH;
          end else cnt <= cnt + 32'd1;
        P_WAIT:
          if (cnt == wlen - 32'd1) begin
            cnt <= '0;
            ph  <= P_IDLE;
          end else cnt <= cnt + 32'd1;
        default: ;
      endcase
  assign e    = ph == P_HIGH;
  assign done = ph == P_WAIT && cnt == wlen - 32'd1;
  assign dato = ph == P_IDLE ? 8'h00 : !pair ? data : {low ? data[3:0] : data[7:4], 4'h0};
endmodule

// File: rtl/lcd_init_seq.sv
// lcd_init_seq: HD44780 power-on initialisation sequencer (8/4-bit bus); LCD_INIT_CURSOR_EN selects cursor+blink display-on
module lcd_init_seq #(
  parameter int BUS4      = 0,
  parameter int LINES     = 2,
  parameter int PWRUP_CYC = 750000,
  parameter int WAKE_CYC  = 205000,
  parameter int WAIT_CYC  = 2000,
  parameter int CLR_CYC   = 82000,
  parameter int EN_CYC    = 12
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Comenzar,
  output logic [7:0] Dato,
  output logic       RS,
  output logic       E,
  output logic       Busy,
  output logic       DoneInit
);
  import lcd_init_pkg::*;
  localparam logic [31:0] PW = clamp1(PWRUP_CYC);
  localparam logic [31:0] WK = clamp1(WAKE_CYC);
  localparam logic [31:0] WT = clamp1(WAIT_CYC);
  localparam logic [31:0] CL = clamp1(CLR_CYC);
  localparam logic [7:0] FSET = (BUS4 != 0 ? {NIB_SET4, 4'h0} : CMD_WAKE) | (LINES == 2 ? 8'h08 : 8'h00);
`ifdef LCD_INIT_CURSOR_EN
  localparam logic [7:0] DON = CMD_DON_CUR;
`else
  localparam logic [7:0] DON = CMD_DON;
`endif
  logic [2:0]  state;
  logic [2:0]  idx;
  logic [31:0] cnt;
  logic        go, sdone, last, pair;
  logic [7:0]  wr_data, cmd_byte;
  logic [31:0] wlen;
  // the current write's byte, bus mode and settle time follow from where the sequence stands
  always_comb begin
    cmd_byte = idx == 3'd0 ? FSET : idx == 3'd1 ? CMD_DOFF : idx == 3'd2 ? CMD_CLR : idx == 3'd3 ? CMD_ENTRY : DON;
    wr_data  = state == ST_CMD ? cmd_byte : state == ST_SET4 ? {NIB_SET4, 4'h0} : CMD_WAKE;
    pair     = state == ST_CMD && BUS4 != 0;
    wlen     = state == ST_CMD ? (idx == 3'd2 ? CL : WT) : (state == ST_WAKE && idx == 3'd0) ? WK : WT;
    last     = state == ST_CMD && idx == 3'd4;
    go       = (state == ST_PWRUP && cnt == PW - 32'd1) || (state == ST_DONE && Comenzar) || (sdone && !last);
  end
  // main sequencer; each done pulse from the strobe unit advances to the next write
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else
      case (state)
        ST_IDLE:
          if (Comenzar) begin
            state <= ST_PWRUP;
            cnt   <= '0;
          end
        ST_PWRUP:
          if (cnt == PW - 32'd1) begin
            state <= ST_WAKE;
            idx   <= '0;
            cnt   <= '0;
          end else cnt <= cnt + 32'd1;
        ST_WAKE:
          if (sdone) begin
            state <= idx == 3'd2 ? (BUS4 != 0 ? ST_SET4 : ST_CMD) : ST_WAKE;
            idx   <= idx == 3'd2 ? 3'd0 : idx + 3'd1;
          end
        ST_SET4:
          if (sdone) begin
            state <= ST_CMD;
            idx   <= '0;
          end
        ST_CMD:
          if (sdone) begin
            state <= last ? ST_DONE : ST_CMD;
            idx   <= last ? 3'd0 : idx + 3'd1;
          end
        ST_DONE:
          if (Comenzar) begin
            state <= ST_WAKE;
            idx   <= '0;
          end
        default: state <= ST_IDLE;
      endcase
  lcd_strobe #(.EN_CYC(EN_CYC)) u_strobe (
    .clk(Clk), .rst(Reset), .go(go), .pair(pair), .data(wr_data), .wlen(wlen),
    .dato(Dato), .e(E), .done(sdone)
  );
  assign RS       = 1'b0;
  assign Busy     = state != ST_IDLE && state != ST_DONE;
  assign DoneInit = state == ST_DONE;
endmodule

// File: doc/lcd_init_seq.md
LCD_INIT_SEQ -- requirements
Module: lcd_init_seq

Interface
REQ-001 SHALL have parameter BUS4, default 0: 0 = 8-bit bus, 1 = 4-bit bus (nibble on Dato[7:4]).
REQ-002 SHALL have parameter LINES, default 2: 1 or 2 display lines, which sets the function-set N bit.
REQ-003 SHALL have parameter PWRUP_CYC, default 750000: power-up wait in cycles (15 ms at 50 MHz).
REQ-004 SHALL have parameter WAKE_CYC, default 205000: wait after the first wake command (4.1 ms).
REQ-005 SHALL have parameter WAIT_CYC, default 2000: wait after each ordinary command (40 us).
REQ-006 SHALL have parameter CLR_CYC, default 82000: wait after clear display (1.64 ms).
REQ-007 SHALL have parameter EN_CYC, default 12: E high width in cycles; also the gap between the two nibbles.
REQ-008 SHALL have port Clk, input, 1 bit: single clock, all state on the rising edge.
REQ-009 SHALL have port Reset, input, 1 bit: asynchronous, active-high.
REQ-010 SHALL have port Comenzar, input, 1 bit: start request, or restart request when in DONE.
REQ-011 SHALL have port Dato, output, 8 bits: LCD data bus.
REQ-012 SHALL have port RS, output, 1 bit: register select, constant 0.
REQ-013 SHALL have port E, output, 1 bit: LCD enable strobe.
REQ-014 SHALL have port Busy, output, 1 bit: sequence in progress.
REQ-015 SHALL have port DoneInit, output, 1 bit: initialisation complete.

Function
REQ-016 SHALL implement main FSM states IDLE, PWRUP, WAKE, SET4, CMD, DONE.
REQ-017 SHALL move IDLE -> PWRUP on the cycle after Comenzar=1 is sampled; Busy=1 from that cycle.
REQ-018 SHALL hold PWRUP for max(PWRUP_CYC,1) cycles, then enter WAKE.
REQ-019 SHALL issue three WAKE writes of 0x30 (4-bit: nibble 0x3) with waits WAKE_CYC, WAIT_CYC, WAIT_CYC.
REQ-020 SHALL, when BUS4=1 only, issue one SET4 single-nibble write of 0x2 with wait WAIT_CYC; SET4 is skipped when BUS4=0.
REQ-021 SHALL issue CMD bytes in order: function set, 0x08, 0x01, 0x06, display-on.
REQ-022 SHALL use function set = 0x30 | (BUS4?0x00:0x08 rearranged as DL) | (LINES==2?0x08:0x00): 8-bit/2-line 0x38, 8-bit/1-line 0x30, 4-bit/2-line 0x28, 4-bit/1-line 0x20.
REQ-023 SHALL wait CLR_CYC after 0x01 and WAIT_CYC after every other command.
REQ-024 SHALL perform each write as: Dato valid with E=0 for 1 setup cycle, E=1 for EN_CYC cycles, E=0 with Dato held until the wait expires.
REQ-025 SHALL, in 4-bit mode, send a full byte as high nibble strobe, EN_CYC low cycles, then low nibble strobe, then the wait; Dato[3:0]=0 throughout.
REQ-026 SHALL clamp any zero-valued wait or width parameter to 1 cycle.
REQ-027 SHALL enter DONE after the display-on wait: Busy=0, DoneInit=1, Dato=0x00, E=0.
REQ-028 SHALL ignore Comenzar while Busy=1.
REQ-029 SHALL, on Comenzar=1 in DONE, drop DoneInit next cycle and restart at WAKE, skipping PWRUP.
REQ-030 SHALL hold RS=0 at all times.

Reset
REQ-031 SHALL, on asynchronous Reset assertion (including mid-strobe), immediately force IDLE, E=0, Dato=0x00, Busy=0, DoneInit=0, and clear all counters.
REQ-032 SHALL leave IDLE after Reset release only on a new Comenzar.

Configuration
REQ-033 SHALL, with LCD_INIT_CURSOR_EN defined, send display-on 0x0F (display, cursor, blink).
REQ-034 SHALL, without LCD_INIT_CURSOR_EN defined, send display-on 0x0C (display only).

Structure
REQ-035 SHALL place the FSM state enum, command constants (0x30, 0x08, 0x01, 0x06, 0x0C, 0x0F), and the nibble-0x2 constant in shared package lcd_init_pkg.
REQ-036 SHALL contain one sub-module, lcd_strobe: setup/E-high/gap/wait counter taking byte, nibble-mode, and wait length, and returning a done pulse.

Verification (sim params PWRUP_CYC=20, WAKE_CYC=10, WAIT_CYC=4, CLR_CYC=8, EN_CYC=2)
REQ-037 SHALL verify BUS4=0, LINES=2, macro defined: Comenzar pulse -> E-strobed bytes 30,30,30,38,08,01,06,0F; E width exactly 2 cycles; DoneInit=1 afterwards.
REQ-038 SHALL verify BUS4=1, LINES=2, macro undefined: nibbles on Dato[7:4] 3,3,3,2,2,8,0,8,0,1,0,6,0,C; 2-cycle gap between paired nibbles.
REQ-039 SHALL verify BUS4=0, LINES=1: function set byte 0x30; the gap from E falling on 0x01 to the next setup cycle is 8 cycles.
REQ-040 SHALL verify Reset asserted while E=1 during the 0x38 strobe -> E=0 and Busy=0 without waiting for a clock edge; the sequence restarts from PWRUP on the next Comenzar.
REQ-041 SHALL verify Comenzar held high throughout the sequence -> no restart while Busy; restart at WAKE (no 20-cycle PWRUP) once in DONE.
REQ-042 SHALL verify PWRUP_CYC=0, WAIT_CYC=0 -> each wait lasts exactly 1 cycle and the sequence still completes.
